// File: rtl/ps2_pkg.sv
// Shared definitions for the ASCII-to-PS/2 keystroke transmitter.
//   state_e       : transmitter FSM states
//   BREAK_PREFIX  : set-2 break prefix sent between make codes
//   MK_*          : set-2 make codes for the letters A-Z
//   odd_parity    : PS/2 parity bit for a data byte
//   frame_bit     : line level for a given bit slot of an 11-slot frame
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    GAP   = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;

  localparam int NUM_SLOTS  = 11;
  localparam int NUM_FRAMES = 3;

  localparam logic [7:0] MK_A = 8'h1C;
  localparam logic [7:0] MK_B = 8'h32;
  localparam logic [7:0] MK_C = 8'h21;
  localparam logic [7:0] MK_D = 8'h23;
  localparam logic [7:0] MK_E = 8'h24;
  localparam logic [7:0] MK_F = 8'h2B;
  localparam logic [7:0] MK_G = 8'h34;
  localparam logic [7:0] MK_H = 8'h33;
  localparam logic [7:0] MK_I = 8'h43;
  localparam logic [7:0] MK_J = 8'h3B;
  localparam logic [7:0] MK_K = 8'h42;
  localparam logic [7:0] MK_L = 8'h4B;
  localparam logic [7:0] MK_M = 8'h3A;
  localparam logic [7:0] MK_N = 8'h31;
  localparam logic [7:0] MK_O = 8'h44;
  localparam logic [7:0] MK_P = 8'h4D;
  localparam logic [7:0] MK_Q = 8'h15;
  localparam logic [7:0] MK_R = 8'h2D;
  localparam logic [7:0] MK_S = 8'h1B;
  localparam logic [7:0] MK_T = 8'h2C;
  localparam logic [7:0] MK_U = 8'h3C;
  localparam logic [7:0] MK_V = 8'h2A;
  localparam logic [7:0] MK_W = 8'h1D;
  localparam logic [7:0] MK_X = 8'h22;
  localparam logic [7:0] MK_Y = 8'h35;
  localparam logic [7:0] MK_Z = 8'h1A;

  // Parity bit chosen so data plus parity carry an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~(^b);
  endfunction

  // Slot 0 start, 1-8 data LSB first, 9 parity, 10 stop.
  function automatic logic frame_bit(input logic [3:0] slot, input logic [7:0] b);
    logic bit_v;
    bit_v = 1'b1;
    case (slot)
      4'd0:    bit_v = 1'b0;
      4'd1:    bit_v = b[0];
      4'd2:    bit_v = b[1];
      4'd3:    bit_v = b[2];
      4'd4:    bit_v = b[3];
      4'd5:    bit_v = b[4];
      4'd6:    bit_v = b[5];
      4'd7:    bit_v = b[6];
      4'd8:    bit_v = b[7];
      4'd9:    bit_v = odd_parity(b);
      default: bit_v = 1'b1;
    endcase
    return bit_v;
  endfunction

endpackage

// File: rtl/ascii2scan.sv
// Combinational ASCII-to-set-2 make-code lookup.
//   ascii : character code
//   scan  : make code (0 when not a letter)
//   ok    : 1 when ascii is A-Z or a-z
module ascii2scan
  import ps2_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [7:0] scan,
  output logic       ok
);

  logic [7:0] up;

  // Lower-case letters fold onto upper case before lookup.
  assign up = (ascii >= 8'd97 && ascii <= 8'd122) ? (ascii - 8'd32) : ascii;

  always_comb begin
    scan = 8'h00;
    ok   = 1'b1;
    case (up)
      8'd65:   scan = MK_A;
      8'd66:   scan = MK_B;
      8'd67:   scan = MK_C;
      8'd68:   scan = MK_D;
      8'd69:   scan = MK_E;
      8'd70:   scan = MK_F;
      8'd71:   scan = MK_G;
      8'd72:   scan = MK_H;
      8'd73:   scan = MK_I;
      8'd74:   scan = MK_J;
      8'd75:   scan = MK_K;
      8'd76:   scan = MK_L;
      8'd77:   scan = MK_M;
      8'd78:   scan = MK_N;
      8'd79:   scan = MK_O;
      8'd80:   scan = MK_P;
      8'd81:   scan = MK_Q;
      8'd82:   scan = MK_R;
      8'd83:   scan = MK_S;
      8'd84:   scan = MK_T;
      8'd85:   scan = MK_U;
      8'd86:   scan = MK_V;
      8'd87:   scan = MK_W;
      8'd88:   scan = MK_X;
      8'd89:   scan = MK_Y;
      8'd90:   scan = MK_Z;
      default: ok   = 1'b0;
    endcase
  end

endmodule

// File: rtl/ascii2ps2_tx.sv
// Sends one keystroke (make, F0, make) for an accepted ASCII letter as
// device-generated PS/2 frames; rejects non-letters with an err pulse.
//   clk, rst : system clock, async active-high reset
//   valid    : ascii holds a character; taken when ready=1
//   ascii    : character code
//   inhibit  : host holding PS/2 clock low; aborts/defers frames
//   ready    : idle, will accept valid
//   ps2_clk  : PS/2 clock level (idle 1)
//   ps2_data : PS/2 data level (idle 1)
//   done     : one-cycle pulse after the third frame completes
//   err      : one-cycle pulse for a rejected character
module ascii2ps2_tx
  import ps2_pkg::*;
#(
  parameter int HALF_CYC = 4000,
  parameter int GAP_CYC  = 8000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] ascii,
  input  logic       inhibit,
  output logic       ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       done,
  output logic       err
);

  localparam int CYC_W = $clog2(2 * HALF_CYC);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(2 * HALF_CYC - 1);
  localparam logic [CYC_W-1:0] CYC_HALF = CYC_W'(HALF_CYC);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  logic [7:0] scan;
  logic       scan_ok;

  ascii2scan u_lookup (
    .ascii (ascii),
    .scan  (scan),
    .ok    (scan_ok)
  );

  state_e           state_q,  state_d;
  logic [CYC_W-1:0] cyc_q,    cyc_d;
  logic [3:0]       slot_q,   slot_d;
  logic [1:0]       frame_q,  frame_d;
  logic [GAP_W-1:0] gap_q,    gap_d;
  logic [7:0]       make_q,   make_d;
  logic             ready_q,  ready_d;
  logic             clk_q,    clk_d;
  logic             data_q,   data_d;
  logic             done_q,   done_d;
  logic             err_q,    err_d;
  logic [7:0]       byte_d;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    slot_d  = slot_q;
    frame_d = frame_q;
    gap_d   = gap_q;
    make_d  = make_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid) begin
          if (scan_ok) begin
            make_d  = scan;
            frame_d = 2'd0;
            slot_d  = 4'd0;
            cyc_d   = '0;
            gap_d   = '0;
            // A host already inhibiting defers the first frame.
            state_d = inhibit ? HOLD : FRAME;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      FRAME: begin
        if (inhibit && slot_q != 4'd10) begin
          // Abort; the same frame restarts from its start bit later.
          state_d = HOLD;
          slot_d  = 4'd0;
          cyc_d   = '0;
        end else if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (slot_q == 4'd10) begin
            slot_d = 4'd0;
            if (frame_q == 2'd2) begin
              state_d = IDLE;
              frame_d = 2'd0;
              done_d  = 1'b1;
            end else begin
              state_d = GAP;
              frame_d = frame_q + 2'd1;
              gap_d   = '0;
            end
          end else begin
            slot_d = slot_q + 4'd1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      GAP: begin
        if (inhibit) begin
          state_d = HOLD;
          gap_d   = '0;
        end else if (gap_q == GAP_LAST) begin
          state_d = FRAME;
          gap_d   = '0;
          slot_d  = 4'd0;
          cyc_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      HOLD: begin
        if (!inhibit) begin
          state_d = GAP;
          gap_d   = '0;
        end
      end

      default: state_d = IDLE;
    endcase

    // Outputs are registered from next state so lines align with the counters.
    byte_d  = (frame_d == 2'd1) ? BREAK_PREFIX : make_d;
    ready_d = (state_d == IDLE);
    clk_d   = (state_d != FRAME) || (cyc_d < CYC_HALF);
    data_d  = (state_d == FRAME) ? frame_bit(slot_d, byte_d) : 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      slot_q  <= 4'd0;
      frame_q <= 2'd0;
      gap_q   <= '0;
      make_q  <= 8'h00;
      ready_q <= 1'b1;
      clk_q   <= 1'b1;
      data_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      slot_q  <= slot_d;
      frame_q <= frame_d;
      gap_q   <= gap_d;
      make_q  <= make_d;
      ready_q <= ready_d;
      clk_q   <= clk_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ready    = ready_q;
  assign ps2_clk  = clk_q;
  assign ps2_data = data_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ascii2ps2_tx.sv
// Directed bench for ascii2ps2_tx with HALF_CYC=4, GAP_CYC=8.
module tb_ascii2ps2_tx;

  localparam int HC  = 4;
  localparam int GC  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] ascii;
  logic       inhibit;
  logic       ready, ps2_clk, ps2_data, done, err;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  ascii2ps2_tx #(.HALF_CYC(HC), .GAP_CYC(GC)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid    (valid),
    .ascii    (ascii),
    .inhibit  (inhibit),
    .ready    (ready),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Expected line level for slot s of a frame carrying byte b.
  function automatic logic fb(input int s, input logic [7:0] b);
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
    if (s == 9) return ~(^b);
    return 1'b1;
  endfunction

  // Starts at the negedge of the frame's first period; checks the first n
  // slots cycle by cycle and returns at the negedge of slot n, cycle 0.
  task automatic check_frame(input string tag, input logic [7:0] b, input int n);
    for (int s = 0; s < n; s++) begin
      for (int c = 0; c < 2*HC; c++) begin
        chk($sformatf("%s_s%0d_c%0d", tag, s, c), {14'd0, ps2_clk, ps2_data},
            {14'd0, (c < HC), fb(s, b)});
        if (c == 0) chk($sformatf("%s_rdy", tag), {15'd0, ready}, 16'd0);
        @(negedge clk);
      end
    end
  endtask

  task automatic check_gap(input string tag);
    for (int i = 0; i < GC; i++) begin
      chk($sformatf("%s_gap%0d", tag, i), {13'd0, ps2_clk, ps2_data, ready}, 16'b110);
      @(negedge clk);
    end
  endtask

  // Full keystroke from a negedge: accept, make/F0/make with gaps, done pulse.
  task automatic keystroke(input string tag, input logic [7:0] ch, input logic [7:0] mk,
                           input bit hold_valid);
    int d0;
    d0 = done_cnt;
    valid = 1'b1;
    ascii = ch;
    @(posedge clk);
    @(negedge clk);
    if (!hold_valid) valid = 1'b0;
    check_frame({tag, "_mk1"}, mk, 11);
    check_gap({tag, "_g1"});
    check_frame({tag, "_f0"}, 8'hF0, 11);
    check_gap({tag, "_g2"});
    check_frame({tag, "_mk2"}, mk, 11);
    chk({tag, "_done"}, {15'd0, done}, 16'd1);
    chk({tag, "_rdy_back"}, {15'd0, ready}, 16'd1);
    valid = 1'b0;
    @(negedge clk);
    chk({tag, "_done_clr"}, {13'd0, done, ps2_clk, ps2_data}, 16'b011);
    #1 chk({tag, "_done_cnt"}, 16'(done_cnt - d0), 16'd1);
  endtask

  initial begin
    int d0;
    bit idle_ok;
    rst = 1'b1; valid = 1'b0; ascii = 8'h00; inhibit = 1'b0;
    #1;
    chk("rst_state", {11'd0, ready, ps2_clk, ps2_data, done, err}, 16'b11100);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst", {11'd0, ready, ps2_clk, ps2_data, done, err}, 16'b11100);

    // 'A' -> 1C / F0 / 1C; done lands on period 3*88+2*8+1 after accept.
    keystroke("A", 8'h41, 8'h1C, 1'b0);

    // 'z' folds to Z -> 1A.
    keystroke("z", 8'h7A, 8'h1A, 1'b0);

    // '1' is rejected.
    valid = 1'b1; ascii = 8'h31;
    @(posedge clk); @(negedge clk);
    valid = 1'b0;
    chk("bad_err", {12'd0, err, ready, ps2_clk, ps2_data}, 16'b1111);
    @(negedge clk);
    chk("bad_err_clr", {15'd0, err}, 16'd0);
    idle_ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!(ps2_clk && ps2_data && ready && !done)) idle_ok = 1'b0;
      @(negedge clk);
    end
    chk("bad_idle200", {15'd0, idle_ok}, 16'd1);

    // Inhibit during slot 5 of F0 for 20 cycles; F0 is resent whole.
    d0 = done_cnt;
    valid = 1'b1; ascii = 8'h51;
    @(posedge clk); @(negedge clk);
    valid = 1'b0;
    check_frame("inh_mk1", 8'h15, 11);
    check_gap("inh_g1");
    check_frame("inh_f0a", 8'hF0, 5);
    inhibit = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("inh_hold%0d", i), {13'd0, ps2_clk, ps2_data, ready}, 16'b110);
    end
    inhibit = 1'b0;
    @(negedge clk);
    check_gap("inh_g1b");
    check_frame("inh_f0b", 8'hF0, 11);
    check_gap("inh_g2");
    check_frame("inh_mk2", 8'h15, 11);
    chk("inh_done", {14'd0, done, ready}, 16'b11);
    @(negedge clk);
    #1 chk("inh_done_cnt", 16'(done_cnt - d0), 16'd1);

    // Reset during slot 3 of the first make code.
    @(negedge clk);
    valid = 1'b1; ascii = 8'h41;
    @(posedge clk); @(negedge clk);
    valid = 1'b0;
    check_frame("rstmid", 8'h1C, 3);
    rst = 1'b1;
    #1 chk("rstmid_lines", {11'd0, ready, ps2_clk, ps2_data, done, err}, 16'b11100);
    @(negedge clk);
    rst = 1'b0;
    keystroke("B", 8'h42, 8'h32, 1'b0);

    // valid held high throughout: one keystroke only.
    d0 = done_cnt;
    keystroke("e_hold", 8'h65, 8'h24, 1'b1);
    idle_ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (!(ps2_clk && ps2_data && ready)) idle_ok = 1'b0;
      @(negedge clk);
    end
    chk("hold_idle", {15'd0, idle_ok}, 16'd1);
    #1 chk("hold_done_cnt", 16'(done_cnt - d0), 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
